// File: rtl/div_ctrl.sv
// div_ctrl: issue/writeback controller for the iterative DIV/DIVU/REM/REMU unit.
// Gates divider starts, tracks the single outstanding divide destination
// (one-entry scoreboard) for RAW/WAW stalls, buffers the divider result and
// writes it back on the shared register-file port when the main pipeline
// leaves it free. A starvation counter force-stalls decode if the buffered
// result keeps losing arbitration for WB_STARVE_MAX cycles.
// Optional build macro: DIV_CTRL_BYPASS_EN adds a forwarding path from the
// result buffer so dependents need not wait for the write.
//
// state | meaning
// IDLE  | no divide outstanding
// WAIT  | divider running
// WB    | result buffered, awaiting the write port
module div_ctrl #(
    parameter int WB_STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dec_div_valid,
    input  logic [4:0]  dec_div_rd,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic        dec_rs1_used,
    input  logic        dec_rs2_used,
    input  logic [4:0]  dec_rd,
    input  logic        dec_rd_wr,
    input  logic        wrb_restart,
    output logic        ctl_stall,
    output logic        div_start,
    output logic        div_flush,
    input  logic        div_busy,
    input  logic        div_ready,
    input  logic [31:0] div_result,
    input  logic        pipe_wb_valid,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
`ifdef DIV_CTRL_BYPASS_EN
    output logic        byp_rs1_hit,
    output logic        byp_rs2_hit,
    output logic [31:0] byp_data,
`endif
    output logic        scb_pending,
    output logic [4:0]  scb_rd
);

    localparam logic [3:0] L_STARVE_MAX = 4'(WB_STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_pend;
    logic [4:0]  r_rd;
    logic [31:0] r_buf;
    logic [3:0]  r_cnt;

    logic w_rs1_match;
    logic w_rs2_match;
    logic w_byp1;
    logic w_byp2;
    logic w_raw;
    logic w_waw;
    logic w_struct;
    logic w_starve;
    logic w_stall;
    logic w_start;
    logic w_wb_fire;

    assign w_rs1_match = dec_rs1_used & (dec_rs1 == r_rd);
    assign w_rs2_match = dec_rs2_used & (dec_rs2 == r_rd);

`ifdef DIV_CTRL_BYPASS_EN
    // A WB-state buffer always holds a nonzero rd, so a match is a valid forward.
    assign w_byp1      = (r_state == S_WB) & w_rs1_match;
    assign w_byp2      = (r_state == S_WB) & w_rs2_match;
    assign byp_rs1_hit = w_byp1;
    assign byp_rs2_hit = w_byp2;
    assign byp_data    = r_buf;
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    assign w_raw    = r_pend & ((w_rs1_match & ~w_byp1) | (w_rs2_match & ~w_byp2));
    assign w_waw    = r_pend & ((dec_rd_wr & (dec_rd == r_rd)) |
                                (dec_div_valid & (dec_div_rd == r_rd)));
    assign w_struct = dec_div_valid & ((r_state != S_IDLE) | div_busy);
    assign w_starve = (r_cnt == L_STARVE_MAX);

    // Combinational outputs are gated by reset so they read 0 while it is held.
    assign w_stall   = ~reset & (w_raw | w_waw | w_struct | w_starve);
    assign w_start   = ~reset & dec_div_valid & ~w_stall & ~wrb_restart & (r_state == S_IDLE);
    assign w_wb_fire = ~reset & (r_state == S_WB) & ~pipe_wb_valid;

    assign ctl_stall   = w_stall;
    assign div_start   = w_start;
    assign div_flush   = ~reset & (r_state == S_WAIT) & wrb_restart;
    assign wb_valid    = w_wb_fire;
    assign wb_rd       = r_rd;
    assign wb_data     = r_buf;
    assign scb_pending = r_pend;
    assign scb_rd      = r_rd;

    // Controller FSM: scoreboard, result buffer and starvation counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pend  <= 1'b0;
            r_rd    <= 5'd0;
            r_buf   <= 32'd0;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 4'd0;
                    if (w_start) begin
                        r_state <= S_WAIT;
                        r_rd    <= dec_div_rd;
                        r_pend  <= (dec_div_rd != 5'd0);
                    end
                end
                S_WAIT: begin
                    r_cnt <= 4'd0;
                    // A flush wins over a same-cycle result: the divide is younger.
                    if (wrb_restart) begin
                        r_state <= S_IDLE;
                        r_pend  <= 1'b0;
                    end else if (div_ready) begin
                        if (r_rd != 5'd0) begin
                            r_buf   <= div_result;
                            r_state <= S_WB;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_WB: begin
                    // The divide is older than any flush here, so wrb_restart is ignored.
                    if (!pipe_wb_valid) begin
                        r_state <= S_IDLE;
                        r_pend  <= 1'b0;
                        r_cnt   <= 4'd0;
                    end else if (r_cnt != L_STARVE_MAX) begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_pend  <= 1'b0;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Issue/writeback controller for the iterative DIV/DIVU/REM/REMU unit.
- Sits between decode, the divider, and the shared register-file write port.
- Gates divider starts and keeps a one-entry scoreboard for the pending destination register, stalling RAW/WAW hazards.
- Buffers the divider's one-cycle result and arbitrates it onto the write port behind the main pipeline, with a starvation guard.

Parameters:
- WB_STARVE_MAX, 8: consecutive cycles a buffered result may lose write-port arbitration before decode is force-stalled; range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- dec_div_valid  in  1  decode presents a DIV/REM instruction
- dec_div_rd  in  5  destination register of that DIV/REM
- dec_rs1  in  5  rs1 number of instruction in decode
- dec_rs2  in  5  rs2 number of instruction in decode
- dec_rs1_used  in  1  decode instruction reads rs1
- dec_rs2_used  in  1  decode instruction reads rs2
- dec_rd  in  5  rd of non-divide instruction in decode
- dec_rd_wr  in  1  non-divide instruction writes dec_rd
- wrb_restart  in  1  pipeline flush
- ctl_stall  out  1  hold decode this cycle
- div_start  out  1  to divider dec_start_div
- div_flush  out  1  to divider wrb_restart
- div_busy  in  1  from divider
- div_ready  in  1  from divider, one-cycle result valid
- div_result  in  32  from divider
- pipe_wb_valid  in  1  main pipeline uses write port this cycle (priority)
- wb_valid  out  1  controller writes register file
- wb_rd  out  5  write register
- wb_data  out  32  write data
- scb_pending  out  1  a divide result to a nonzero rd is outstanding
- scb_rd  out  5  its register number

Behaviour:
- Clocking: reset is asynchronous, active-high; clock is clk. All state updates on posedge clk.
- Reset values: state IDLE, scb_pending=0, scb_rd=0, result buffer=0, starve counter=0. All outputs are 0.
- States:
  - IDLE: no divide outstanding.
  - WAIT: divider running.
  - WB: result buffered, awaiting the write port.
- Hazard terms (pend = scb_pending):
  - raw = pend & ((dec_rs1_used & dec_rs1==scb_rd) | (dec_rs2_used & dec_rs2==scb_rd))
  - waw = pend & ((dec_rd_wr & dec_rd==scb_rd) | (dec_div_valid & dec_div_rd==scb_rd))
  - struct = dec_div_valid & (state!=IDLE | div_busy)
  - starve = (starve counter == WB_STARVE_MAX)
  - ctl_stall = raw | waw | struct | starve
- div_start = dec_div_valid & !ctl_stall & !wrb_restart & state==IDLE.
- On div_start:
  - next state is WAIT.
  - scb_rd <= dec_div_rd.
  - scb_pending <= (dec_div_rd != 0).
- WAIT:
  - div_flush = wrb_restart.
  - If wrb_restart: go to IDLE, clear scb_pending, and ignore a simultaneous div_ready.
  - Else if div_ready and scb_rd != 0: capture div_result into the buffer and go to WB.
  - Else if div_ready and scb_rd == 0: go to IDLE; the result is discarded.
  - No assumption on divider latency.
- WB:
  - wb_valid = !pipe_wb_valid; wb_rd = scb_rd; wb_data = buffer.
  - When wb_valid=1: go to IDLE, clear scb_pending, zero the starve counter.
  - When pipe_wb_valid=1: the starve counter increments, saturating at WB_STARVE_MAX.
  - The counter is zeroed in every non-WB state.
  - wrb_restart in WB has no effect: the divide completed and is older than the flush. div_flush stays 0.
- A hazard clears in the cycle the write occurs: ctl_stall drops combinationally on the next cycle, so the dependent instruction issues one cycle after wb_valid.
- wrb_restart in IDLE: no state change, div_start forced 0.
- Outside WB, wb_valid=0; wb_rd and wb_data hold their last values (don't-care).
- The divider's same-operand result reuse is not exploited: a new divide cannot issue until IDLE.

Optional Feature:
- Macro: DIV_CTRL_BYPASS_EN.
- With the macro defined:
  - Adds outputs byp_rs1_hit (1), byp_rs2_hit (1), byp_data (32).
  - In WB, a source matching scb_rd asserts its hit, and byp_data = buffer.
  - The raw term excludes matching sources, so dependents issue without stalling.
  - waw is unchanged.
- Without the macro: the ports are absent and raw stalls until the write.

Test Plan:
- Reset mid-WAIT: reset asserted while WAIT -> all outputs 0 immediately, state IDLE; no wb_valid after release.
- Basic: DIV rd=5, src1=100, src2=7; pipe_wb_valid=0 -> div_start for one cycle; scb_pending=1, scb_rd=5 until wb_valid with wb_rd=5, wb_data=14 one cycle after div_ready; then scb_pending=0.
- RAW stall: REMU rd=3 (45/7) then ADD reading x3 -> ctl_stall held until the wb_valid cycle; wb_data=3. With DIV_CTRL_BYPASS_EN: no stall in WB, byp_rs1_hit=1, byp_data=3.
- Starvation: WB with pipe_wb_valid=1 continuously, WB_STARVE_MAX=8 -> ctl_stall=1 after 8 cycles; drop pipe_wb_valid -> wb_valid=1 that cycle, counter=0.
- Flush: wrb_restart during WAIT -> div_flush=1, IDLE next cycle, scb_pending=0, no write. wrb_restart coincident with div_ready -> result discarded. wrb_restart in WB -> write still occurs.
- rd=0 and structural: DIV rd=0 -> scb_pending never set, no wb_valid. Second DIV presented during WAIT -> ctl_stall=1 and div_start=0 until IDLE.
